// File: rtl/par_frame_rx.sv
// par_frame_rx -- serial-to-parallel frame receiver.
//
// Collects DATA_BITS data bits (first bit received lands in the MSB) plus one
// trailing parity bit from a valid/ready serial stream. Each completed frame
// is presented as word/p through a valid/ready handshake. A one-frame pending
// buffer absorbs downstream backpressure so a finished frame is never lost.
//
// Optional feature macro: PAR_FRAME_RX_CHECK_EN
//   When defined, adds a registered even-parity flag (par_ok) and a
//   saturating 8-bit counter of odd-parity frames handed off (err_cnt).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   sin        in   serial bit
//   sin_valid  in   sin is valid this cycle
//   sin_ready  out  receiver accepts a bit this cycle
//   abort      in   discard partially received frame
//   word       out  received data [DATA_BITS-1:0]
//   p          out  received parity bit
//   out_valid  out  word/p hold a frame
//   out_ready  in   downstream takes the frame
//   par_ok     out  (macro only) ~^{word, p}
//   err_cnt    out  (macro only) saturating count of bad-parity handoffs

module par_frame_rx #(
    parameter int DATA_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 sin_valid,
    output logic                 sin_ready,
    input  logic                 abort,
    output logic [DATA_BITS-1:0] word,
    output logic                 p,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef PAR_FRAME_RX_CHECK_EN
    ,
    output logic                 par_ok,
    output logic [7:0]           err_cnt
`endif
);

    localparam int CW = $clog2(DATA_BITS + 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] STALL   = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS:0]   pend_q, pend_d;      // {data, parity}
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 p_q, p_d;
    logic                 out_valid_q, out_valid_d;

    logic accept;
    logic handoff;
    logic out_free;

    // Ready depends only on registered state, never on out_ready.
    assign sin_ready = (state_q == COLLECT) & ~rst;
    // Abort in COLLECT wins over a bit presented in the same cycle.
    assign accept    = sin_valid & sin_ready & ~abort;
    assign handoff   = out_valid_q & out_ready;
    assign out_free  = ~out_valid_q | out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        pend_d      = pend_q;
        word_d      = word_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;

        // A load below overrides this clear when a new frame arrives.
        if (handoff) out_valid_d = 1'b0;

        if (state_q == COLLECT) begin
            if (abort) begin
                cnt_d   = '0;
                shreg_d = '0;
            end else if (accept) begin
                if (cnt_q != CW'(DATA_BITS)) begin
                    shreg_d = DATA_BITS'({shreg_q, sin});
                    cnt_d   = cnt_q + CW'(1);
                end else if (out_free) begin
                    word_d      = shreg_q;
                    p_d         = sin;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    pend_d  = {shreg_q, sin};
                    state_d = STALL;
                end
            end
        end else begin
            // out_valid is necessarily 1 here, so out_ready means a handoff.
            if (out_ready) begin
                word_d      = pend_q[DATA_BITS:1];
                p_d         = pend_q[0];
                out_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            shreg_q     <= '0;
            pend_q      <= '0;
            word_q      <= '0;
            p_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            pend_q      <= pend_d;
            word_q      <= word_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign word      = word_q;
    assign p         = p_q;
    assign out_valid = out_valid_q;

`ifdef PAR_FRAME_RX_CHECK_EN
    logic       par_ok_q, par_ok_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        // Recomputed from next-state output so it tracks every load.
        par_ok_d  = ~^{word_d, p_d};
        err_cnt_d = err_cnt_q;
        if (handoff && !par_ok_q && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_ok_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            par_ok_q  <= par_ok_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign par_ok  = par_ok_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_par_frame_rx.sv
module tb_par_frame_rx;

    localparam int DB = 3;

    logic          clk;
    logic          rst;
    logic          sin;
    logic          sin_valid;
    logic          sin_ready;
    logic          abort;
    logic [DB-1:0] word;
    logic          p;
    logic          out_valid;
    logic          out_ready;
`ifdef PAR_FRAME_RX_CHECK_EN
    logic          par_ok;
    logic [7:0]    err_cnt;
`endif

    int checks;
    int failures;

    // Reference model: bits of the frame in progress, and frames held by the
    // receiver (output slot first, then pending) as {word, parity}.
    logic     bits[$];
    logic [DB:0] oq[$];
    int       merr;

    par_frame_rx #(.DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .abort     (abort),
        .word      (word),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PAR_FRAME_RX_CHECK_EN
        ,
        .par_ok    (par_ok),
        .err_cnt   (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_ready();
        return (oq.size() < 2) && !rst;
    endfunction

    // Advance one clock, updating the model from the inputs applied this cycle.
    task automatic tick();
        logic rdy;
        logic [DB:0] f;
        rdy = exp_ready();
        if (rst) begin
            bits.delete();
            oq.delete();
            merr = 0;
        end else begin
            if (oq.size() > 0 && out_ready) begin
                if (^oq[0] && merr < 255) merr++;
                void'(oq.pop_front());
            end
            if (rdy && abort) bits.delete();
            else if (rdy && sin_valid) begin
                bits.push_back(sin);
                if (bits.size() == DB + 1) begin
                    f = '0;
                    foreach (bits[i]) f = (f << 1) | (DB+1)'(bits[i]);
                    oq.push_back(f);
                    bits.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        sin_valid = 1'b1;
        sin       = b;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sin_valid = 1'b1; sin = 1'b1; out_ready = 1'b0; abort = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({out_valid, word, p, sin_ready} !== '0) begin
            failures++;
            $display("FAIL reset_state got ov=%b w=%b p=%b rdy=%b want all 0", out_valid, word, p, sin_ready);
        end
        rst = 1'b0; sin_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", sin_ready);
        end
        tick();
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        send(1); send(0); send(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got %b want 0 (no bits counted in reset)", out_valid);
        end
        send(0);
        @(negedge clk);
        checks++;
        if ({out_valid, word, p} !== {1'b1, 3'b101, 1'b0}) begin
            failures++;
            $display("FAIL single_frame got ov=%b w=%b p=%b want 1/101/0", out_valid, word, p);
        end
`ifdef PAR_FRAME_RX_CHECK_EN
        checks++;
        if (par_ok !== 1'b1) begin
            failures++;
            $display("FAIL single_par_ok got %b want 1", par_ok);
        end
`endif
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(1); send(1); send(0); send(0);
        send(0); send(1); send(1); send(1);
        // Hold a bit on the line while stalled; it must not be taken.
        sin_valid = 1'b1; sin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sin_ready, out_valid, word, p} !== {1'b0, 1'b1, 3'b110, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got rdy=%b ov=%b w=%b p=%b want 0/1/110/0", i, sin_ready, out_valid, word, p);
            end
            tick();
        end
        sin_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({sin_ready, out_valid, word, p} !== {1'b1, 1'b1, 3'b011, 1'b1}) begin
            failures++;
            $display("FAIL bp_second got rdy=%b ov=%b w=%b p=%b want 1/1/011/1", sin_ready, out_valid, word, p);
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        send(1); send(1);
        abort = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        abort = 1'b0; sin_valid = 1'b0;
        send(0); send(0); send(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_early got ov=%b want 0", out_valid);
        end
        send(1);
        @(negedge clk);
        checks++;
        if ({out_valid, word, p} !== {1'b1, 3'b001, 1'b1}) begin
            failures++;
            $display("FAIL abort_frame got ov=%b w=%b p=%b want 1/001/1", out_valid, word, p);
        end
        tick();
    endtask

    task automatic test_gapped();
        logic [3:0] seq;
        seq = 4'b1111;
        out_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send(seq[i]);
            if (i != 0) begin
                tick(); tick();
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_early[%0d] got ov=%b want 0", i, out_valid);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({out_valid, word, p} !== {1'b1, 3'b111, 1'b1}) begin
            failures++;
            $display("FAIL gap_frame got ov=%b w=%b p=%b want 1/111/1", out_valid, word, p);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            sin_valid = ($urandom_range(0, 9) < 7);
            sin       = 1'($urandom);
            abort     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < (c < 1500 ? 3 : 8));
            @(negedge clk);
            checks++;
            if (sin_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d got %b want %b", c, sin_ready, exp_ready());
            end
            checks++;
            if (out_valid !== (oq.size() > 0)) begin
                failures++;
                $display("FAIL rnd_valid cyc=%0d got %b want %b", c, out_valid, oq.size() > 0);
            end
            if (oq.size() > 0) begin
                checks++;
                if ({word, p} !== oq[0]) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got %b want %b", c, {word, p}, oq[0]);
                end
`ifdef PAR_FRAME_RX_CHECK_EN
                checks++;
                if (par_ok !== ~^oq[0]) begin
                    failures++;
                    $display("FAIL rnd_par_ok cyc=%0d got %b want %b", c, par_ok, ~^oq[0]);
                end
`endif
            end
`ifdef PAR_FRAME_RX_CHECK_EN
            checks++;
            if (err_cnt !== 8'(merr)) begin
                failures++;
                $display("FAIL rnd_err_cnt cyc=%0d got %0d want %0d", c, err_cnt, merr);
            end
`endif
            tick();
        end
        rst = 1'b0; abort = 1'b0; sin_valid = 1'b0;
    endtask

`ifdef PAR_FRAME_RX_CHECK_EN
    task automatic test_check_en();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        send(1); send(1); send(1); send(0);
        @(negedge clk);
        checks++;
        if (par_ok !== 1'b0) begin
            failures++;
            $display("FAIL chk_par_ok got %b want 0", par_ok);
        end
        tick();
        @(negedge clk);
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL chk_err_one got %0d want 1", err_cnt);
        end
        for (int n = 0; n < 299; n++) begin
            send(1); send(1); send(1); send(0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL chk_err_sat got %0d want 255", err_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0; failures = 0; merr = 0;
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_abort();
        test_gapped();
        test_random();
`ifdef PAR_FRAME_RX_CHECK_EN
        test_check_en();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
